picorv32_wb_bridge: RTL and testbench
=====================================

# picorv32_wb_bridge

Parametrised bridge from the PicoRV32 native memory port to a classic Wishbone B4 master. It adds termination on `wbm_err_i`, bounded retry on `wbm_rty_i`, and a per-transfer timeout, and reports faults through a status side-band. It sits between `picorv32` and the SoC Wishbone interconnect, one instance per core. Every bus fault still completes the CPU request, so the core never hangs.

## Interface
Parameters:
- `ADDR_W`, 32: address width, mem and Wishbone side.
- `DATA_W`, 32: data width; legal values 32 or 64. `SEL_W = DATA_W/8`.
- `TIMEOUT`, 255: cycles `wbm_stb_o` may stay high per attempt; 0 disables the timeout.
- `MAX_RETRY`, 3: re-issues allowed after `wbm_rty_i` before the transfer is declared failed.
- `ERR_RDATA`, `32'hDEAD_BEEF`: value returned on a failed read, zero-extended to `DATA_W`.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_ni` in 1: asynchronous, active-low reset.
- `mem_valid` in 1: CPU request.
- `mem_instr` in 1: instruction fetch; latched into `err_instr_o` only.
- `mem_addr` in `ADDR_W`: request address.
- `mem_wdata` in `DATA_W`: write data.
- `mem_wstrb` in `SEL_W`: byte strobes; 0 means read.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_rdata` out `DATA_W`: read data.
- `wbm_adr_o` out `ADDR_W`, `wbm_dat_o` out `DATA_W`, `wbm_sel_o` out `SEL_W`, `wbm_we_o` out 1, `wbm_stb_o` out 1, `wbm_cyc_o` out 1: Wishbone master outputs, all registered.
- `wbm_dat_i` in `DATA_W`, `wbm_ack_i` in 1, `wbm_err_i` in 1, `wbm_rty_i` in 1: Wishbone slave responses.
- `busy_o` out 1: state ≠ IDLE.
- `bus_err_o` out 1: one-cycle pulse, coincident with a failed `mem_ready`.
- `err_code_o` out 2: 01 = err, 10 = retry exhausted, 11 = timeout. Sticky until the next fault.
- `err_addr_o` out `ADDR_W`, `err_instr_o` out 1: address and `mem_instr` of the last fault. Sticky.

## Operation
- **States:** IDLE, REQ, RGAP (retry gap), DONE.
- **IDLE:**
  - On `mem_valid`, latch `adr`/`dat`.
  - `wbm_we_o = |mem_wstrb`.
  - `wbm_sel_o = mem_wstrb` for writes, all ones for reads.
  - Assert `stb`/`cyc`, clear the retry and timeout counters, go to REQ.
- **REQ:** response priority is `wbm_err_i` > `wbm_ack_i` > `wbm_rty_i` > timeout.
  - **ack:** on reads, load `mem_rdata <= wbm_dat_i`; on writes, `mem_rdata` holds its value. Pulse `mem_ready`, drop `stb`/`cyc`/`we`, go to DONE.
  - **err:** fault code 01.
  - **rty:**
    - While retry count < `MAX_RETRY`: increment it, drop `stb`/`cyc`, go to RGAP.
    - Otherwise: fault code 10.
  - **Timeout:** when `TIMEOUT` ≠ 0 and the counter reaches `TIMEOUT - 1` with no response, raise fault code 11.
- **Fault:**
  - On reads, load `mem_rdata <= ERR_RDATA`.
  - Pulse `mem_ready` and `bus_err_o`; update `err_code_o`, `err_addr_o`, `err_instr_o`.
  - Drop `stb`/`cyc`/`we`, go to DONE.
- **RGAP:** one idle bus cycle. Re-assert `stb`/`cyc` with the same latched fields, clear the timeout counter, go to REQ.
- **DONE:** `mem_ready <= 0`, go to IDLE. This blocks a relaunch on the CPU's stale `mem_valid`.
- The `mem_*` inputs are ignored outside IDLE. The latched request is never altered mid-transfer.
- The timeout counter is `clog2(TIMEOUT+1)` bits wide and saturates. The retry counter is `clog2(MAX_RETRY+1)` bits wide.

## Timing
- **Reset:** asynchronous assert, synchronous deassert at the SoC level. While reset is low:
  - all outputs are 0, including `mem_rdata`, `err_*` and `wbm_*`; state is IDLE;
  - a reset mid-transfer drops `cyc`/`stb` immediately, and no `mem_ready` is issued.
- **Launch:** `mem_valid` sampled at edge N puts `stb`/`cyc` high from N+1.
- **Completion:** a response sampled at edge M puts `mem_ready` high for exactly cycle M+1, with `stb` low in that same cycle. IDLE is reached at M+2.
- **Best case:** a zero-wait slave acks at N+1, giving `mem_ready` at N+2 and 3 cycles request to request.
- **Retry:** each retry adds 2 cycles: the RGAP cycle plus re-issue.
- **Timeout:** fires on the `TIMEOUT`-th cycle of `stb` high without a response.
- **`mem_ready`** is never high in two consecutive cycles.

## Test plan
- **Zero-wait traffic:** read at 0x100 with ack at first sampled edge, `dat_i=0x12345678`; then write `wstrb=0x3` -> read: `mem_rdata=0x12345678`, `sel=0xF`, `we=0`, `mem_ready` 2 cycles after `mem_valid`. Write: `sel=0x3`, `we=1`, `mem_rdata` unchanged. No relaunch during DONE.
- **Error:** read with `wbm_err_i` after 2 waits -> `mem_rdata=0xDEADBEEF`, `bus_err_o` pulse, `err_code_o=01`, `err_addr_o` = request address.
- **Retry then success:** `rty` twice, then ack -> two RGAP gaps with `cyc` low, identical `adr` each attempt, single `mem_ready`, no `bus_err_o`.
- **Retry exhausted and simultaneous responses:**
  - `rty` 4 times with `MAX_RETRY=3` -> `err_code_o=10` after the 4th.
  - `err` and `ack` together -> treated as error.
- **Timeout:** with `TIMEOUT=8` and a silent slave -> `stb` high exactly 8 cycles, `err_code_o=11`, `mem_ready` pulse. An ack arriving on the 8th cycle instead completes normally.
- **Reset mid-transfer:** assert `wb_rst_ni=0` during REQ -> `cyc`/`stb` low asynchronously, no `mem_ready`. The next request after release runs normally.

Source files
------------

// File: rtl/picorv32_wb_bridge.sv
// PicoRV32 native memory port to Wishbone B4 classic master bridge.
// Bus errors, exhausted retries and timeouts all still complete the CPU request, and each one is logged in the err_* side-band.
module picorv32_wb_bridge #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          TIMEOUT   = 255,
  parameter int          MAX_RETRY = 3,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF,
  localparam int         SEL_W     = DATA_W / 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [SEL_W-1:0]  mem_wstrb,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  output logic              wbm_we_o,
  output logic              wbm_stb_o,
  output logic              wbm_cyc_o,
  input  logic [DATA_W-1:0] wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  input  logic              wbm_rty_i,
  output logic              busy_o,
  output logic              bus_err_o,
  output logic [1:0]        err_code_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic              err_instr_o
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0]     RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [DATA_W-1:0] ERR_DATA  = DATA_W'(ERR_RDATA);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RGAP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] F_NONE  = 2'b00;
  localparam logic [1:0] F_ERR   = 2'b01;
  localparam logic [1:0] F_RETRY = 2'b10;
  localparam logic [1:0] F_TMO   = 2'b11;

  logic [1:0]    state;
  logic [TW-1:0] tmo_cnt;
  logic [RW-1:0] retry_cnt;
  logic          instr_q;

  logic          complete;
  logic          retry;
  logic [1:0]    fault;

  assign busy_o = (state != IDLE);

  // Response resolution in REQ: err beats ack beats rty beats timeout.
  always_comb begin
    complete = 1'b0;
    retry    = 1'b0;
    fault    = F_NONE;
    if (state == REQ) begin
      if (wbm_err_i) begin
        complete = 1'b1;
        fault    = F_ERR;
      end else if (wbm_ack_i) begin
        complete = 1'b1;
      end else if (wbm_rty_i) begin
        if (retry_cnt < RETRY_LIM) begin
          retry = 1'b1;
        end else begin
          complete = 1'b1;
          fault    = F_RETRY;
        end
      end else if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
        complete = 1'b1;
        fault    = F_TMO;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      retry_cnt   <= '0;
      instr_q     <= 1'b0;
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      wbm_we_o    <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      bus_err_o   <= 1'b0;
      err_code_o  <= 2'b00;
      err_addr_o  <= '0;
      err_instr_o <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      bus_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid) begin
            wbm_adr_o <= mem_addr;
            wbm_dat_o <= mem_wdata;
            wbm_we_o  <= |mem_wstrb;
            wbm_sel_o <= (|mem_wstrb) ? mem_wstrb : '1;
            wbm_stb_o <= 1'b1;
            wbm_cyc_o <= 1'b1;
            instr_q   <= mem_instr;
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (complete) begin
            if (!wbm_we_o) mem_rdata <= (fault != F_NONE) ? ERR_DATA : wbm_dat_i;
            if (fault != F_NONE) begin
              bus_err_o   <= 1'b1;
              err_code_o  <= fault;
              err_addr_o  <= wbm_adr_o;
              err_instr_o <= instr_q;
            end
            mem_ready <= 1'b1;
            wbm_stb_o <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            state     <= DONE;
          end else if (retry) begin
            retry_cnt <= retry_cnt + 1'b1;
            wbm_stb_o <= 1'b0;
            wbm_cyc_o <= 1'b0;
            state     <= RGAP;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RGAP: begin
          wbm_stb_o <= 1'b1;
          wbm_cyc_o <= 1'b1;
          tmo_cnt   <= '0;
          state     <= REQ;
        end
        // DONE swallows the CPU's still-high mem_valid so it cannot relaunch.
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_wb_bridge.sv
// Scoreboard bench for picorv32_wb_bridge: a scripted Wishbone slave, a transaction-level
// outcome model and a monitor that checks every mem_ready against the predicted result.
module tb_picorv32_wb_bridge;

  localparam int TIMEOUT   = 8;
  localparam int MAX_RETRY = 3;
  localparam int K_ACK = 0, K_ERR = 1, K_ERRACK = 2, K_SILENT = 3;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
    logic        instr;
    int          n_rty;
    int          w_rty;
    int          w_fin;
    int          kind;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        bus_err;
    logic [1:0]  code;
    logic [31:0] err_addr;
    logic        err_instr;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_stb_o, wbm_cyc_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0, wbm_rty_i = 1'b0;
  logic        busy_o, bus_err_o, err_instr_o;
  logic [1:0]  err_code_o;
  logic [31:0] err_addr_o;

  int checks = 0;
  int errors = 0;

  txn_t slave_q[$];
  exp_t exp_q[$];

  logic [31:0] m_rdata = '0, m_addr = '0;
  logic [1:0]  m_code = '0;
  logic        m_instr = 1'b0;

  picorv32_wb_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY),
    .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .wbm_rty_i(wbm_rty_i),
    .busy_o(busy_o), .bus_err_o(bus_err_o), .err_code_o(err_code_o),
    .err_addr_o(err_addr_o), .err_instr_o(err_instr_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(logic [31:0] a, logic [3:0] s, logic [31:0] wd, logic [31:0] rd,
                              int nr, int wr, int wf, int k, logic ins);
    txn_t t;
    t.addr = a; t.wstrb = s; t.wdata = wd; t.rdata = rd; t.n_rty = nr;
    t.w_rty = wr; t.w_fin = wf; t.kind = k; t.instr = ins;
    return t;
  endfunction

  // Outcome of a whole transfer, derived from the slave script and the fault rules.
  function automatic exp_t predict(txn_t t);
    exp_t e;
    int code;
    if (t.n_rty > MAX_RETRY) code = 2;
    else if (t.kind == K_SILENT || t.w_fin >= TIMEOUT) code = 3;
    else if (t.kind == K_ACK) code = 0;
    else code = 1;
    if (code == 2) e.lat = (MAX_RETRY + 1) * (t.w_rty + 1) + MAX_RETRY + 1;
    else e.lat = t.n_rty * (t.w_rty + 2) + ((code == 3) ? TIMEOUT : t.w_fin + 1) + 1;
    if (t.wstrb == 4'h0) m_rdata = (code != 0) ? 32'hDEAD_BEEF : t.rdata;
    if (code != 0) begin
      m_code = 2'(code); m_addr = t.addr; m_instr = t.instr;
    end
    e.rdata = m_rdata; e.bus_err = (code != 0); e.code = m_code;
    e.err_addr = m_addr; e.err_instr = m_instr;
    return e;
  endfunction

  task automatic applyStimulus(input txn_t t, input int gap);
    bit seen = 0;
    @(negedge clk);
    slave_q.push_back(t);
    exp_q.push_back(predict(t));
    mem_valid = 1'b1; mem_addr = t.addr; mem_wdata = t.wdata;
    mem_wstrb = t.wstrb; mem_instr = t.instr;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (mem_ready) seen = 1;
    end
    if (!seen) begin
      errors++; checks++;
      $display("[TB] FAIL ready_timeout got=0 expected=1 addr=%0h", t.addr);
    end
    // Like the real core, mem_valid is only dropped after the ready edge.
    @(posedge clk);
    #1 mem_valid = 1'b0;
    mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom); mem_instr = 1'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  // Scripted slave: per attempt, answer after w stb cycles; rty for the first n_rty attempts.
  txn_t cur;
  bit   cur_valid = 0, in_att = 0;
  int   attempt = 0, cnt = 0;
  always @(negedge clk) begin
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
    if (!rst_n) begin
      cur_valid = 0; in_att = 0; attempt = 0; slave_q.delete();
    end else if (wbm_stb_o) begin
      if (!cur_valid) begin
        if (slave_q.size() == 0) begin
          errors++; checks++;
          $display("[TB] FAIL unexpected_stb got=1 expected=0 at %0t", $time);
        end else begin
          cur = slave_q.pop_front(); cur_valid = 1; attempt = 0; in_att = 0;
        end
      end
      if (cur_valid) begin
        if (!in_att) begin
          in_att = 1; cnt = 0;
          checkOutput("wb_adr", wbm_adr_o, cur.addr);
          checkOutput("wb_we", wbm_we_o, (cur.wstrb != 0));
          checkOutput("wb_sel", wbm_sel_o, (cur.wstrb != 0) ? cur.wstrb : 4'hF);
          checkOutput("wb_cyc", wbm_cyc_o, 1);
          if (cur.wstrb != 0) checkOutput("wb_dat", wbm_dat_o, cur.wdata);
        end
        if (cnt == ((attempt < cur.n_rty) ? cur.w_rty : cur.w_fin)) begin
          if (attempt < cur.n_rty) wbm_rty_i = 1'b1;
          else if (cur.kind == K_ACK) begin wbm_ack_i = 1'b1; wbm_dat_i = cur.rdata; end
          else if (cur.kind == K_ERR) wbm_err_i = 1'b1;
          else if (cur.kind == K_ERRACK) begin wbm_err_i = 1'b1; wbm_ack_i = 1'b1; wbm_dat_i = cur.rdata; end
        end
        cnt++;
      end
    end else if (in_att) begin
      in_att = 0;
      if (wbm_cyc_o) checkOutput("cyc_in_gap", wbm_cyc_o, 0);
      if (mem_ready) cur_valid = 0;
      else attempt++;
    end
  end

  // Monitor: pop the oldest prediction whenever the bridge completes a request.
  int busy_cnt = 0;
  bit prev_ready = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0; prev_ready = 0;
    end else begin
      if (busy_o) busy_cnt++;
      else busy_cnt = 0;
      if (bus_err_o && !mem_ready) checkOutput("bus_err_without_ready", bus_err_o, 0);
      if (mem_ready) begin
        checkOutput("ready_back_to_back", prev_ready, 0);
        checkOutput("stb_during_ready", wbm_stb_o, 0);
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("[TB] FAIL unexpected_ready got=1 expected=0 at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("mem_rdata", mem_rdata, e.rdata);
          checkOutput("bus_err", bus_err_o, e.bus_err);
          checkOutput("err_code", err_code_o, e.code);
          checkOutput("err_addr", err_addr_o, e.err_addr);
          checkOutput("err_instr", err_instr_o, e.err_instr);
          checkOutput("latency", busy_cnt, e.lat);
        end
      end
      prev_ready = mem_ready;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    txn_t t;
    int r, k;
    #12;
    checkOutput("rst_ctrl", {mem_ready, wbm_stb_o, wbm_cyc_o, wbm_we_o, busy_o, bus_err_o, err_instr_o}, 0);
    checkOutput("rst_data", {mem_rdata, wbm_adr_o}, 0);
    checkOutput("rst_err", {err_code_o, err_addr_o, wbm_sel_o, wbm_dat_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(mk(32'h100, 4'h0, 32'h0,        32'h12345678, 0, 0, 0, K_ACK,    1'b0), 0);
    applyStimulus(mk(32'h104, 4'h3, 32'hCAFEF00D, 32'h0,        0, 0, 0, K_ACK,    1'b0), 1);
    applyStimulus(mk(32'h200, 4'h0, 32'h0,        32'h11111111, 0, 0, 2, K_ERR,    1'b1), 0);
    applyStimulus(mk(32'h300, 4'h0, 32'h0,        32'h33333333, 2, 0, 0, K_ACK,    1'b0), 2);
    applyStimulus(mk(32'h400, 4'hF, 32'h44444444, 32'h0,        4, 0, 0, K_ACK,    1'b0), 0);
    applyStimulus(mk(32'h500, 4'h0, 32'h0,        32'h55555555, 0, 0, 1, K_ERRACK, 1'b0), 0);
    applyStimulus(mk(32'h600, 4'h0, 32'h0,        32'h0,        0, 0, 0, K_SILENT, 1'b1), 0);
    applyStimulus(mk(32'h700, 4'h0, 32'h0,        32'h77777777, 0, 0, 7, K_ACK,    1'b0), 1);

    // Reset in the middle of a transfer that the slave never answers.
    @(negedge clk);
    slave_q.push_back(mk(32'h900, 4'h0, 32'h0, 32'h0, 0, 0, 0, K_SILENT, 1'b0));
    mem_valid = 1'b1; mem_addr = 32'h900; mem_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midrst_stb_cyc", {wbm_stb_o, wbm_cyc_o}, 0);
    checkOutput("midrst_ready_busy", {mem_ready, busy_o}, 0);
    checkOutput("midrst_err", {err_code_o, err_addr_o}, 0);
    mem_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_no_ready", {mem_ready, wbm_cyc_o}, 0);
    rst_n = 1'b1;
    m_rdata = '0; m_code = '0; m_addr = '0; m_instr = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(mk(32'h800, 4'h0, 32'h0, 32'h88888888, 0, 0, 1, K_ACK, 1'b0), 0);

    for (int n = 0; n < 40; n++) begin
      t.addr  = $urandom & 32'hFFFF_FFFC;
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      t.instr = 1'($urandom);
      r = $urandom_range(0, 9);
      t.n_rty = (r < 6) ? 0 : r - 5;
      t.w_rty = $urandom_range(0, 2);
      k = $urandom_range(0, 9);
      t.kind  = (k < 6 || k == 9) ? K_ACK : (k == 6) ? K_ERR : (k == 7) ? K_ERRACK : K_SILENT;
      t.w_fin = (k == 9) ? $urandom_range(6, 9) : $urandom_range(0, 4);
      applyStimulus(t, $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    checkOutput("pending_expectations", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
